qr_decode_ctrl: RTL
===================

Name: qr_decode_ctrl

Overview:
Top-level sequencer for the QR decoder pipeline; owns the 4-bit `state` bus consumed by the scan, rotate, demask and decode engines. Arbitrates the single 1-bit-wide image SRAM read port among the engines by state. Counts decoded symbols against the total reported by the NUM engine, then signals completion.

Parameters:
ADDR_W, 12, SRAM read address width (64x64 image)
CNT_W, 3, width of symbol counters
PRE_CYCLES, 4, dwell cycles in PRE_SCAN (SRAM priming); legal range 1..15
TIMEOUT, 4095, per-state cycle limit (WATCHDOG_EN only)

Ports:
clk  in  1  clock, all flops rising edge
srst  in  1  reset, synchronous, active-high
qr_decode_start  in  1  start request, sampled only in IDLE
num_addr  in  ADDR_W  NUM engine read address
num_done  in  1  NUM engine finished
num_total  in  CNT_W  symbol count, valid with num_done
scan_addr  in  ADDR_W  scan engine read address
scan_hit  in  1  candidate finder found
scan_end  in  1  image exhausted
rotate_addr  in  ADDR_W  rotate engine read address
rot_ok  in  1  orientation resolved
rot_fail  in  1  all four orientations rejected (false candidate)
dec_addr  in  ADDR_W  demask/decode read address
demask_done  in  1  demask finished
decode_done  in  1  one symbol decoded
state  out  4  current state encoding
state_entry  out  1  pulse, first cycle of any new state
sram_raddr  out  ADDR_W  arbitrated SRAM read address
qr_total  out  CNT_W  latched symbol total
qr_idx  out  CNT_W  symbols decoded so far
qr_decode_finish  out  1  one-cycle completion pulse
err  out  1  sticky error flag, cleared on start

Behaviour:
- State encoding fixed: IDLE=0, PRE_SCAN=1, NUM=2, SCAN=3, ROTATE=4, LOC=5, DEMASK=6, DECODE=7, FINISH=8; codes 9-15 -> IDLE next cycle.
- Reset: state=IDLE, every output 0, internal counters 0.
- IDLE: qr_decode_start=1 -> PRE_SCAN; clears qr_idx, qr_total, err.
- PRE_SCAN: dwell exactly PRE_CYCLES cycles -> NUM.
- NUM: num_done -> latch num_total into qr_total; total 0 -> FINISH, else SCAN.
- SCAN: scan_hit -> ROTATE; else scan_end -> FINISH with err=1 (fewer symbols than total). Hit wins if both in same cycle.
- ROTATE: rot_ok -> LOC; else rot_fail -> SCAN (scan engine resumes). ok wins if both.
- LOC: exactly 1 cycle -> DEMASK.
- DEMASK: demask_done -> DECODE.
- DECODE: decode_done -> qr_idx+1; if new qr_idx == qr_total -> FINISH else SCAN.
- FINISH: qr_decode_finish=1 for exactly 1 cycle -> IDLE.
- Done/hit inputs outside their own state ignored; qr_decode_start outside IDLE ignored.
- state, qr_total, qr_idx, err registered.
- state_entry high in the first cycle state holds a new value. Not asserted on self-loops or after reset.
- sram_raddr combinational mux, zero latency: PRE_SCAN/NUM -> num_addr; SCAN -> scan_addr; ROTATE/LOC -> rotate_addr; DEMASK/DECODE -> dec_addr; else 0.
- qr_idx saturates at 2^CNT_W-1; never wraps.
- srst mid-operation: next cycle IDLE, all outputs 0, no finish pulse.

Optional Feature:
QR_CTRL_WATCHDOG_EN.
- Defined:
  - Per-state 12-bit cycle counter, cleared on every state change.
  - In NUM/SCAN/ROTATE/DEMASK/DECODE, reaching TIMEOUT forces FINISH and sets err=1.
- Undefined: no counter; engines may hold a state indefinitely.

Decomposition:
- Package qr_pkg: state enum/localparams (0-8), ADDR_W, CNT_W defaults.
- Sub-module qr_sram_mux: state-indexed address mux, so other masters can later reuse it.
- FSM, counters and watchdog stay in qr_decode_ctrl.

Test Plan:
1. Reset, start; PRE_CYCLES=4 -> states 1 for 4 cycles then 2; num_done with num_total=2 -> SCAN, qr_total=2.
2. Full two-symbol run: hit, rot_ok, demask_done, decode_done twice -> qr_idx=2, FINISH, one-cycle qr_decode_finish, IDLE, err=0.
3. ROTATE with rot_fail -> back to SCAN, qr_idx unchanged. Same-cycle scan_hit+scan_end -> ROTATE, err stays 0.
4. num_total=0 -> NUM straight to FINISH. scan_end before total reached -> FINISH, err=1.
5. Drive distinct addresses (num=0x011, scan=0x022, rotate=0x033, dec=0x044) -> sram_raddr tracks each in its states, 0 in IDLE/FINISH.
6. srst asserted in DEMASK -> IDLE next cycle, outputs 0. With WATCHDOG_EN and TIMEOUT=15, SCAN stalled 15 cycles -> FINISH, err=1.

Source files
------------

// File: rtl/qr_pkg.sv
// Shared state codes and default widths for the QR decoder control slice.
// Declarations only: no latency or flow control of its own.
package qr_pkg;

   localparam int QR_ADDR_W = 12;
   localparam int QR_CNT_W  = 3;

   typedef logic [3:0] qr_state_t;

   // Codes are fixed: the scan/rotate/demask/decode engines decode this bus directly.
   localparam qr_state_t ST_IDLE     = 4'd0;
   localparam qr_state_t ST_PRE_SCAN = 4'd1;
   localparam qr_state_t ST_NUM      = 4'd2;
   localparam qr_state_t ST_SCAN     = 4'd3;
   localparam qr_state_t ST_ROTATE   = 4'd4;
   localparam qr_state_t ST_LOC      = 4'd5;
   localparam qr_state_t ST_DEMASK   = 4'd6;
   localparam qr_state_t ST_DECODE   = 4'd7;
   localparam qr_state_t ST_FINISH   = 4'd8;

endpackage

// File: rtl/qr_sram_mux.sv
// State-indexed read-address mux for the single image SRAM port; zero latency.
// No backpressure: the owning engine is chosen purely by the sequencer state.
module qr_sram_mux
   import qr_pkg::*;
#(
   parameter int ADDR_W = QR_ADDR_W
)(
   input  logic [3:0]        i_state,
   input  logic [ADDR_W-1:0] i_num_addr,
   input  logic [ADDR_W-1:0] i_scan_addr,
   input  logic [ADDR_W-1:0] i_rotate_addr,
   input  logic [ADDR_W-1:0] i_dec_addr,
   output logic [ADDR_W-1:0] o_raddr
);

   always_comb begin
      o_raddr = '0;
      case (i_state)
         ST_PRE_SCAN, ST_NUM: o_raddr = i_num_addr;
         ST_SCAN:             o_raddr = i_scan_addr;
         ST_ROTATE, ST_LOC:   o_raddr = i_rotate_addr;
         ST_DEMASK, ST_DECODE: o_raddr = i_dec_addr;
         default:             o_raddr = '0;
      endcase
   end

endmodule

// File: rtl/qr_decode_ctrl.sv
// QR decoder sequencer: registered state/counters, one-cycle state transitions, comb SRAM mux.
// Engines hold a state by withholding their done/hit; optional QR_CTRL_WATCHDOG_EN bounds that.
module qr_decode_ctrl
   import qr_pkg::*;
#(
   parameter int ADDR_W     = QR_ADDR_W,
   parameter int CNT_W      = QR_CNT_W,
   parameter int PRE_CYCLES = 4
`ifdef QR_CTRL_WATCHDOG_EN
   , parameter int TIMEOUT  = 4095
`endif
)(
   input  logic              clk,
   input  logic              srst,
   input  logic              qr_decode_start,
   input  logic [ADDR_W-1:0] num_addr,
   input  logic              num_done,
   input  logic [CNT_W-1:0]  num_total,
   input  logic [ADDR_W-1:0] scan_addr,
   input  logic              scan_hit,
   input  logic              scan_end,
   input  logic [ADDR_W-1:0] rotate_addr,
   input  logic              rot_ok,
   input  logic              rot_fail,
   input  logic [ADDR_W-1:0] dec_addr,
   input  logic              demask_done,
   input  logic              decode_done,
   output logic [3:0]        state,
   output logic              state_entry,
   output logic [ADDR_W-1:0] sram_raddr,
   output logic [CNT_W-1:0]  qr_total,
   output logic [CNT_W-1:0]  qr_idx,
   output logic              qr_decode_finish,
   output logic              err
);

   localparam logic [3:0] PRE_LAST = 4'(PRE_CYCLES - 1);

   logic [3:0]       r_state;
   logic             r_entry;
   logic [CNT_W-1:0] r_total;
   logic [CNT_W-1:0] r_idx;
   logic             r_err;
   logic [3:0]       r_pre;

   logic [3:0]       w_next;
   logic [CNT_W-1:0] w_total_nxt;
   logic [CNT_W-1:0] w_idx_nxt;
   logic [CNT_W-1:0] w_idx_inc;
   logic             w_err_nxt;

   assign w_idx_inc = (r_idx == '1) ? r_idx : r_idx + 1'b1;

`ifdef QR_CTRL_WATCHDOG_EN
   localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);
   logic [11:0] r_wdog;
   logic        w_wd_fire;

   assign w_wd_fire = (r_state inside {ST_NUM, ST_SCAN, ST_ROTATE, ST_DEMASK, ST_DECODE})
                      && (r_wdog == TMO_LAST);

   always_ff @(posedge clk) begin
      if (srst || (w_next != r_state)) r_wdog <= '0;
      else if (r_wdog != '1)           r_wdog <= r_wdog + 12'd1;
   end
`endif

   always_comb begin
      w_next      = r_state;
      w_total_nxt = r_total;
      w_idx_nxt   = r_idx;
      w_err_nxt   = r_err;
      case (r_state)
         ST_IDLE: if (qr_decode_start) begin
            w_next      = ST_PRE_SCAN;
            w_total_nxt = '0;
            w_idx_nxt   = '0;
            w_err_nxt   = 1'b0;
         end
         ST_PRE_SCAN: if (r_pre == PRE_LAST) w_next = ST_NUM;
         ST_NUM: if (num_done) begin
            w_total_nxt = num_total;
            w_next      = (num_total == '0) ? ST_FINISH : ST_SCAN;
         end
         // A hit outranks image exhaustion seen in the same cycle.
         ST_SCAN: if (scan_hit) w_next = ST_ROTATE;
                  else if (scan_end) begin
                     w_next    = ST_FINISH;
                     w_err_nxt = 1'b1;
                  end
         ST_ROTATE: if (rot_ok) w_next = ST_LOC;
                    else if (rot_fail) w_next = ST_SCAN;
         ST_LOC:    w_next = ST_DEMASK;
         ST_DEMASK: if (demask_done) w_next = ST_DECODE;
         ST_DECODE: if (decode_done) begin
            w_idx_nxt = w_idx_inc;
            w_next    = (w_idx_inc == r_total) ? ST_FINISH : ST_SCAN;
         end
         ST_FINISH: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
`ifdef QR_CTRL_WATCHDOG_EN
      if (w_wd_fire) begin
         w_next    = ST_FINISH;
         w_err_nxt = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (srst || (r_state != ST_PRE_SCAN)) r_pre <= '0;
      else                                  r_pre <= r_pre + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_state <= ST_IDLE;
         r_entry <= 1'b0;
         r_total <= '0;
         r_idx   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_entry <= (w_next != r_state);
         r_total <= w_total_nxt;
         r_idx   <= w_idx_nxt;
         r_err   <= w_err_nxt;
      end
   end

   qr_sram_mux #(.ADDR_W(ADDR_W)) u_sram_mux (
      .i_state       (r_state),
      .i_num_addr    (num_addr),
      .i_scan_addr   (scan_addr),
      .i_rotate_addr (rotate_addr),
      .i_dec_addr    (dec_addr),
      .o_raddr       (sram_raddr)
   );

   assign state            = r_state;
   assign state_entry      = r_entry;
   assign qr_total         = r_total;
   assign qr_idx           = r_idx;
   assign err              = r_err;
   assign qr_decode_finish = (r_state == ST_FINISH);

endmodule
